// File: rtl/reg_writeback_unit.sv
// Register-file write-back stage: buffers retiring MEM/WB entries in order,
// waits on load returns where needed, and issues one registered write pulse per commit.
module reg_writeback_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic                  in_is_load,
    input  logic                  in_wb_en,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0] write_reg_data,
    output logic                  reg_write,
    output logic                  pending_valid,
    output logic [ADDR_WIDTH-1:0] pending_rd,
    output logic                  busy,
    output logic [15:0]           retire_count,
    output logic                  err_unexpected_load,
    output logic                  state_dbg_o
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Handshake: an entry transfers on a clock edge where in_valid && in_ready;
    // in_ready depends only on the registered occupancy, so a full buffer never
    // accepts in the same cycle it retires an entry.

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  reg_write_q, reg_write_d;
    logic [15:0]           retire_q, retire_d;
    logic                  err_q, err_d;

    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_alu;
    logic                  head_is_load;
    logic                  head_wb_en;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] commit_data;

    assign empty        = (count_q == '0);
    assign in_ready     = (count_q != CW'(FIFO_DEPTH));
    assign push         = in_valid && in_ready;

    // Entry layout, MSB first: {rd, alu_result, is_load, wb_en}
    assign head         = fifo_q[rd_ptr_q];
    assign head_rd      = head[EW-1 -: ADDR_WIDTH];
    assign head_alu     = head[DATA_WIDTH+1 : 2];
    assign head_is_load = head[1];
    assign head_wb_en   = head[0];

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        commit_data = head_alu;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (!head_is_load) begin
                        pop = 1'b1;
                    end else if (load_valid) begin
                        pop         = 1'b1;
                        commit_data = load_data;
                    end else begin
                        state_d = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (load_valid) begin
                    pop         = 1'b1;
                    commit_data = load_data;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        retire_d     = retire_q;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        if (pop) begin
            write_reg_d  = head_rd;
            write_data_d = commit_data;
            reg_write_d  = head_wb_en && (head_rd != '0);
            retire_d     = retire_q + 16'd1;
        end
        // A strobe is stray unless a load sits at the head; its data is dropped.
        err_d = err_q || (load_valid && (empty || !head_is_load));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            retire_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            retire_q     <= retire_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {in_rd, in_alu_result, in_is_load, in_wb_en};
        end
    end

    assign write_reg           = write_reg_q;
    assign write_reg_data      = write_data_q;
    assign reg_write           = reg_write_q;
    assign retire_count        = retire_q;
    assign err_unexpected_load = err_q;
    assign busy                = !empty || reg_write_q;
    assign pending_valid       = !empty && head_wb_en && (head_rd != '0);
    assign pending_rd          = empty ? '0 : head_rd;
    assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an in-order queue model.
module tb_reg_writeback_unit;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [7:0]  in_alu_result;
    logic        in_is_load;
    logic        in_wb_en;
    logic        load_valid;
    logic [7:0]  load_data;
    logic [4:0]  write_reg;
    logic [7:0]  write_reg_data;
    logic        reg_write;
    logic        pending_valid;
    logic [4:0]  pending_rd;
    logic        busy;
    logic [15:0] retire_count;
    logic        err_unexpected_load;
    logic        state_dbg_o;

    int n_tests = 0;
    int n_fail  = 0;

    reg_writeback_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .in_is_load(in_is_load), .in_wb_en(in_wb_en),
        .load_valid(load_valid), .load_data(load_data),
        .write_reg(write_reg), .write_reg_data(write_reg_data), .reg_write(reg_write),
        .pending_valid(pending_valid), .pending_rd(pending_rd), .busy(busy),
        .retire_count(retire_count), .err_unexpected_load(err_unexpected_load),
        .state_dbg_o(state_dbg_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of {rd, alu, is_load, wb_en}; outputs follow from the rules directly.
    logic [14:0] exp_q[$];
    logic [4:0]  m_wr_reg;
    logic [7:0]  m_wr_data;
    logic        m_rw;
    logic [15:0] m_rc;
    logic        m_err;
    logic        m_wait;
    bit          m_ok = 0;

    always @(posedge clock) begin : model
        logic [14:0] h;
        bit ne, ready, commit;
        if (reset) begin
            exp_q.delete();
            m_wr_reg = '0; m_wr_data = '0; m_rw = 0; m_rc = '0; m_err = 0; m_wait = 0;
            m_ok = 1;
        end else if (m_ok) begin
            ne     = exp_q.size() != 0;
            ready  = exp_q.size() != DEPTH;
            h      = ne ? exp_q[0] : '0;
            m_rw   = 0;
            if (load_valid && (!ne || !h[1])) m_err = 1;
            commit = ne && (!h[1] || load_valid);
            m_wait = ne && h[1] && !load_valid;
            if (commit) begin
                m_wr_reg  = h[14:10];
                m_wr_data = h[1] ? load_data : h[9:2];
                m_rw      = h[0] && (h[14:10] != 5'd0);
                m_rc      = m_rc + 16'd1;
                exp_q.delete(0);
            end
            if (in_valid && ready) exp_q.push_back({in_rd, in_alu_result, in_is_load, in_wb_en});
        end
    end

    always @(negedge clock) begin : compare
        logic [14:0] h;
        bit ne;
        if (m_ok) begin
            ne = exp_q.size() != 0;
            h  = ne ? exp_q[0] : '0;
            chk("in_ready", in_ready, exp_q.size() != DEPTH);
            chk("write_reg", write_reg, m_wr_reg);
            chk("write_reg_data", write_reg_data, m_wr_data);
            chk("reg_write", reg_write, m_rw);
            chk("pending_valid", pending_valid, ne && h[0] && (h[14:10] != 5'd0));
            chk("pending_rd", pending_rd, ne ? h[14:10] : 5'd0);
            chk("busy", busy, ne || m_rw);
            chk("retire_count", retire_count, m_rc);
            chk("err_unexpected_load", err_unexpected_load, m_err);
            chk("state_wait", state_dbg_o, m_wait);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [7:0] alu, input logic ld, input logic wb);
        bit done = 0;
        in_valid = 1; in_rd = rd; in_alu_result = alu; in_is_load = ld; in_wb_en = wb;
        for (int i = 0; i < 40 && !done; i++) begin
            done = in_ready;
            step();
        end
        in_valid = 0;
        chk("push_accept", done, 1);
    endtask

    initial begin
        bit acc;
        reset = 1; in_valid = 0; in_rd = 0; in_alu_result = 0; in_is_load = 0; in_wb_en = 0;
        load_valid = 0; load_data = 0;
        step(); step();
        reset = 0;
        chk("rst_write_reg", write_reg, 0);
        chk("rst_write_data", write_reg_data, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_err", err_unexpected_load, 0);
        chk("rst_ready", in_ready, 1);

        // Single non-load commit one edge after the push
        push(5'd5, 8'h3C, 0, 1);
        step();
        chk("t1_rw", reg_write, 1);
        chk("t1_wr", write_reg, 5);
        chk("t1_data", write_reg_data, 8'h3C);
        chk("t1_rc", retire_count, 1);
        step();
        chk("t1_rw_drop", reg_write, 0);

        // Load waits for its data return
        push(5'd7, 8'h00, 1, 1);
        chk("t2_pend_rd", pending_rd, 7);
        chk("t2_pend_v", pending_valid, 1);
        step();
        chk("t2_wait", state_dbg_o, 1);
        step(); step();
        load_valid = 1; load_data = 8'hA5;
        step();
        load_valid = 0;
        chk("t2_rw", reg_write, 1);
        chk("t2_wr", write_reg, 7);
        chk("t2_data", write_reg_data, 8'hA5);
        step();

        // Backpressure behind a stalled load
        push(5'd9, 8'h00, 1, 1);
        push(5'd1, 8'h11, 0, 1);
        in_valid = 1; in_rd = 5'd2; in_alu_result = 8'h22; in_is_load = 0; in_wb_en = 1;
        chk("t3_full", in_ready, 0);
        step(); step();
        chk("t3_full2", in_ready, 0);
        load_valid = 1; load_data = 8'h5A;
        step();
        load_valid = 0;
        chk("t3_ld_wr", write_reg, 9);
        chk("t3_ld_data", write_reg_data, 8'h5A);
        chk("t3_ready", in_ready, 1);
        step();
        in_valid = 0;
        chk("t3_wr1", write_reg, 1);
        chk("t3_data1", write_reg_data, 8'h11);
        step();
        chk("t3_wr2", write_reg, 2);
        chk("t3_data2", write_reg_data, 8'h22);
        push(5'd3, 8'h33, 0, 1);
        step();
        chk("t3_wr3", write_reg, 3);
        chk("t3_rc", retire_count, 6);

        // x0 and wb_en=0 retire without writing
        push(5'd0, 8'hFF, 0, 1);
        push(5'd3, 8'h44, 0, 0);
        chk("t4_rw0", reg_write, 0);
        step();
        chk("t4_rw1", reg_write, 0);
        chk("t4_rc", retire_count, 8);

        // Stray load strobe, then reset while waiting on a load
        load_valid = 1; load_data = 8'h77;
        step();
        load_valid = 0;
        chk("t5_err", err_unexpected_load, 1);
        step(); step();
        chk("t5_err_sticky", err_unexpected_load, 1);
        push(5'd4, 8'h00, 1, 1);
        step();
        chk("t5_wait", state_dbg_o, 1);
        reset = 1;
        step();
        reset = 0;
        chk("t5_busy", busy, 0);
        chk("t5_rw", reg_write, 0);
        chk("t5_rc", retire_count, 0);
        chk("t5_err_clr", err_unexpected_load, 0);
        chk("t5_pend", pending_valid, 0);
        load_valid = 1;
        step();
        load_valid = 0;
        chk("t5_err_after", err_unexpected_load, 1);

        // Random traffic; offers are held until accepted
        acc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid      = $urandom_range(0, 3) != 0;
                in_rd         = 5'($urandom_range(0, 31));
                in_alu_result = 8'($urandom_range(0, 255));
                in_is_load    = $urandom_range(0, 2) == 0;
                in_wb_en      = $urandom_range(0, 4) != 0;
            end
            load_valid = $urandom_range(0, 3) == 0;
            load_data  = 8'($urandom_range(0, 255));
            reset      = $urandom_range(0, 199) == 0;
            acc        = in_valid && in_ready && !reset;
            step();
        end
        reset = 1; in_valid = 0; load_valid = 0;
        step();
        reset = 0;

        // retire_count wrap
        in_valid = 1; in_is_load = 0; in_wb_en = 1;
        for (int i = 0; i < 65535; i++) begin
            in_rd         = 5'($urandom_range(0, 31));
            in_alu_result = 8'($urandom_range(0, 255));
            step();
        end
        in_valid = 0;
        step();
        chk("t6_rc_max", retire_count, 16'hFFFF);
        push(5'd6, 8'h66, 0, 1);
        step();
        chk("t6_rc_wrap", retire_count, 0);
        chk("t6_wr", write_reg, 6);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
